// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counters plus target store, trained from
// execute-stage resolutions, with mispredict/redirect generation and saturating statistics.
module branch_predictor #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            ex_mispredict_o,
  output logic [XLEN-1:0] ex_redirect_pc_o,
  output logic [15:0]     branch_cnt_o,
  output logic [15:0]     mispred_cnt_o
);

  localparam int unsigned Entries = 1 << IDX_W;

  logic [1:0]      ctr_q    [Entries];
  logic [1:0]      ctr_d    [Entries];
  logic            valid_q  [Entries];
  logic            valid_d  [Entries];
  logic [XLEN-1:0] target_q [Entries];
  logic [XLEN-1:0] target_d [Entries];
  logic [15:0]     branch_cnt_q, branch_cnt_d;
  logic [15:0]     mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             train;

  assign if_idx = if_pc_i[IDX_W+1:2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];
  assign train  = ex_valid_i & ex_is_branch_i;

  // Prediction reads registered state only, so a same-cycle update is never bypassed.
  assign pred_taken_o  = valid_q[if_idx] & ctr_q[if_idx][1];
  assign pred_target_o = target_q[if_idx];

  always_comb begin
    ex_mispredict_o = 1'b0;
    if (ex_valid_i) begin
      if (ex_is_branch_i) begin
        ex_mispredict_o = (ex_taken_i != ex_pred_taken_i) |
                          (ex_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i));
      end else begin
        // A non-branch predicted taken is an alias hit and must be squashed.
        ex_mispredict_o = ex_pred_taken_i;
      end
    end
  end

  assign ex_redirect_pc_o = (ex_is_branch_i & ex_taken_i) ? ex_target_i
                                                          : ex_pc_i + XLEN'(4);

  always_comb begin
    ctr_d    = ctr_q;
    valid_d  = valid_q;
    target_d = target_q;
    if (train) begin
      if (ex_taken_i) begin
        if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
        valid_d[ex_idx]  = 1'b1;
        target_d[ex_idx] = ex_target_i;
      end else if (ctr_q[ex_idx] != 2'b00) begin
        ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (train && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
    if (ex_mispredict_o && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i]    <= 2'b01;
        valid_q[i]  <= 1'b0;
        target_q[i] <= '0;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ctr_q         <= ctr_d;
      valid_q       <= valid_d;
      target_q      <= target_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic against
// a behavioural table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  int nchk = 0;
  int nerr = 0;

  // Behavioural model state
  int          m_ctr   [16];
  bit          m_valid [16];
  logic [31:0] m_tgt   [16];
  int          m_bcnt, m_mcnt;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .IDX_W(4)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .if_pc_i          (if_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ex_valid_i       (ex_valid),
    .ex_is_branch_i   (ex_is_branch),
    .ex_pc_i          (ex_pc),
    .ex_taken_i       (ex_taken),
    .ex_target_i      (ex_target),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .ex_mispredict_o  (ex_mispredict),
    .ex_redirect_pc_o (ex_redirect_pc),
    .branch_cnt_o     (branch_cnt),
    .mispred_cnt_o    (mispred_cnt)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic m_misp();
    if (!ex_valid) return 1'b0;
    if (!ex_is_branch) return ex_pred_taken;
    if (ex_taken != ex_pred_taken) return 1'b1;
    return ex_taken && (ex_target != ex_pred_target);
  endfunction

  function automatic logic [31:0] m_redir();
    if (ex_is_branch && ex_taken) return ex_target;
    return ex_pc + 32'd4;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 1; m_valid[i] = 0; m_tgt[i] = '0;
    end
    m_bcnt = 0; m_mcnt = 0;
  endfunction

  // Advance the model by the effect of the current inputs, then clock the DUT.
  task automatic tick();
    if (!rstn) begin
      m_reset();
    end else begin
      if (m_misp()) m_mcnt = (m_mcnt < 65535) ? m_mcnt + 1 : 65535;
      if (ex_valid && ex_is_branch) begin
        int i = idx_of(ex_pc);
        if (ex_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_valid[i] = 1; m_tgt[i] = ex_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
        m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; if_pc = 32'h40;
    drive(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    rstn = 1'b1;
    #1;
    nchk++; if (pred_taken !== 1'b0) begin nerr++; $display("FAIL reset_pred_taken got %0h exp 0", pred_taken); end
    nchk++; if (pred_target !== 32'h0) begin nerr++; $display("FAIL reset_pred_target got %0h exp 0", pred_target); end
    nchk++; if (branch_cnt !== 16'h0) begin nerr++; $display("FAIL reset_branch_cnt got %0h exp 0", branch_cnt); end
    nchk++; if (mispred_cnt !== 16'h0) begin nerr++; $display("FAIL reset_mispred_cnt got %0h exp 0", mispred_cnt); end
    nchk++; if (ex_mispredict !== 1'b0) begin nerr++; $display("FAIL reset_mispredict got %0h exp 0", ex_mispredict); end
    nchk++; if (ex_redirect_pc !== 32'h0) begin nerr++; $display("FAIL redirect_wrap got %0h exp 0", ex_redirect_pc); end
  endtask

  task automatic test_train_taken();
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    nchk++; if (ex_mispredict !== 1'b1) begin nerr++; $display("FAIL first_taken_misp got %0h exp 1", ex_mispredict); end
    nchk++; if (ex_redirect_pc !== 32'h100) begin nerr++; $display("FAIL first_taken_redir got %0h exp 100", ex_redirect_pc); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    nchk++; if (pred_taken !== 1'b1) begin nerr++; $display("FAIL trained_pred got %0h exp 1", pred_taken); end
    nchk++; if (pred_target !== 32'h100) begin nerr++; $display("FAIL trained_target got %0h exp 100", pred_target); end
    nchk++; if (branch_cnt !== 16'd1) begin nerr++; $display("FAIL bcnt_after_1 got %0d exp 1", branch_cnt); end
    nchk++; if (mispred_cnt !== 16'd1) begin nerr++; $display("FAIL mcnt_after_1 got %0d exp 1", mispred_cnt); end
  endtask

  task automatic test_saturate_and_not_taken();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      nchk++; if (ex_mispredict !== 1'b0) begin nerr++; $display("FAIL correct_taken_misp[%0d] got %0h exp 0", k, ex_mispredict); end
      tick();
    end
    drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    nchk++; if (ex_mispredict !== 1'b1) begin nerr++; $display("FAIL not_taken_misp got %0h exp 1", ex_mispredict); end
    nchk++; if (ex_redirect_pc !== 32'h44) begin nerr++; $display("FAIL not_taken_redir got %0h exp 44", ex_redirect_pc); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    // From a saturated 11, one not-taken leaves 10 which still predicts taken.
    nchk++; if (pred_taken !== 1'b1) begin nerr++; $display("FAIL after_one_nt_pred got %0h exp 1", pred_taken); end
  endtask

  task automatic test_collision();
    if_pc = 32'h88;
    drive(1'b1, 1'b1, 32'h88, 1'b1, 32'h300, 1'b0, 32'h0);
    nchk++; if (pred_taken !== 1'b0) begin nerr++; $display("FAIL collision_same_cycle got %0h exp 0", pred_taken); end
    nchk++; if (pred_target !== 32'h0) begin nerr++; $display("FAIL collision_old_target got %0h exp 0", pred_target); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    nchk++; if (pred_taken !== 1'b1) begin nerr++; $display("FAIL collision_next_cycle got %0h exp 1", pred_taken); end
    nchk++; if (pred_target !== 32'h300) begin nerr++; $display("FAIL collision_next_target got %0h exp 300", pred_target); end
  endtask

  task automatic test_alias();
    if_pc = 32'h40;
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    tick();
    drive(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b1, 32'h100);
    nchk++; if (ex_mispredict !== 1'b1) begin nerr++; $display("FAIL alias_misp got %0h exp 1", ex_mispredict); end
    nchk++; if (ex_redirect_pc !== 32'h84) begin nerr++; $display("FAIL alias_redir got %0h exp 84", ex_redirect_pc); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    nchk++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      nerr++; $display("FAIL alias_table got %0h/%0h exp 1/100", pred_taken, pred_target);
    end
    nchk++; if (branch_cnt !== 16'd7) begin nerr++; $display("FAIL alias_bcnt got %0d exp 7", branch_cnt); end
    nchk++; if (mispred_cnt !== 16'd4) begin nerr++; $display("FAIL alias_mcnt got %0d exp 4", mispred_cnt); end
  endtask

  task automatic test_target_mismatch();
    if_pc = 32'h40;
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
    nchk++; if (ex_mispredict !== 1'b1) begin nerr++; $display("FAIL tgt_mismatch_misp got %0h exp 1", ex_mispredict); end
    nchk++; if (ex_redirect_pc !== 32'h200) begin nerr++; $display("FAIL tgt_mismatch_redir got %0h exp 200", ex_redirect_pc); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    nchk++; if (pred_target !== 32'h200) begin nerr++; $display("FAIL tgt_updated got %0h exp 200", pred_target); end
    nchk++; if (branch_cnt !== 16'd8 || mispred_cnt !== 16'd5) begin
      nerr++; $display("FAIL counts_after_directed got %0d/%0d exp 8/5", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pc, tgt, ptgt;
      logic        tk, ptk, br;
      if_pc = {$urandom_range(0, 3), 26'h0, 4'h0} | (32'($urandom_range(0, 31)) << 2);
      pc    = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      tgt   = 32'($urandom_range(0, 7)) << 8;
      tk    = 1'($urandom_range(0, 1));
      br    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        ptk = m_pred(pc); ptgt = m_tgt[idx_of(pc)];
      end else begin
        ptk = 1'($urandom_range(0, 1)); ptgt = 32'($urandom_range(0, 7)) << 8;
      end
      drive(($urandom_range(0, 4) != 0), br, pc, tk, tgt, ptk, ptgt);
      nchk++; if (pred_taken !== m_pred(if_pc)) begin
        nerr++; $display("FAIL rnd_pred[%0d] got %0h exp %0h", k, pred_taken, m_pred(if_pc));
      end
      nchk++; if (pred_target !== m_tgt[idx_of(if_pc)]) begin
        nerr++; $display("FAIL rnd_target[%0d] got %0h exp %0h", k, pred_target, m_tgt[idx_of(if_pc)]);
      end
      nchk++; if (ex_mispredict !== m_misp()) begin
        nerr++; $display("FAIL rnd_misp[%0d] got %0h exp %0h", k, ex_mispredict, m_misp());
      end
      nchk++; if (ex_redirect_pc !== m_redir()) begin
        nerr++; $display("FAIL rnd_redir[%0d] got %0h exp %0h", k, ex_redirect_pc, m_redir());
      end
      nchk++; if (branch_cnt !== 16'(m_bcnt) || mispred_cnt !== 16'(m_mcnt)) begin
        nerr++; $display("FAIL rnd_counts[%0d] got %0d/%0d exp %0d/%0d", k, branch_cnt, mispred_cnt,
                         m_bcnt, m_mcnt);
      end
      tick();
    end
  endtask

  task automatic test_saturation_and_reset();
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    for (int k = 0; k < 70000; k++) tick();
    nchk++; if (branch_cnt !== 16'hFFFF) begin nerr++; $display("FAIL sat_bcnt got %0h exp ffff", branch_cnt); end
    nchk++; if (mispred_cnt !== 16'hFFFF) begin nerr++; $display("FAIL sat_mcnt got %0h exp ffff", mispred_cnt); end
    tick();
    nchk++; if (branch_cnt !== 16'hFFFF || mispred_cnt !== 16'hFFFF) begin
      nerr++; $display("FAIL sat_hold got %0h/%0h exp ffff/ffff", branch_cnt, mispred_cnt);
    end
    // Reset with training still active: nothing from that cycle may survive.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    if_pc = 32'h40;
    #1;
    nchk++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      nerr++; $display("FAIL midreset_table got %0h/%0h exp 0/0", pred_taken, pred_target);
    end
    nchk++; if (branch_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
      nerr++; $display("FAIL midreset_counts got %0h/%0h exp 0/0", branch_cnt, mispred_cnt);
    end
    // Weakly not-taken restored: a single taken flips the prediction.
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    nchk++; if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin
      nerr++; $display("FAIL post_reset_train got %0h/%0h exp 1/500", pred_taken, pred_target);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_train_taken();
    test_saturate_and_not_taken();
    test_collision();
    test_alias();
    test_target_mismatch();
    test_random();
    test_saturation_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
